mag_sqrt_ctrl: RTL
==================

Name: mag_sqrt_ctrl

Overview:
- Front/back-end controller wrapped around the sqrt_u32 stage.
- Accepts signed I/Q sample pairs with tags over a valid/ready handshake and computes x = I² + Q² in a 2-stage pipeline.
- Issues x to sqrt_u32 (vld_in/x). sqrt_u32 has no backpressure, so issue is credit-limited to keep its 16-deep input FIFO from overflowing.
- Captures y/vld_out into a result buffer and presents {magnitude, tag} downstream in order, with backpressure.

Parameters:
- CREDITS, 16: max samples accepted but not yet popped downstream. Must be ≤ sqrt_u32 FIFO depth. Power of two, ≥ 2.
- TAG_W, 4: width of the user tag carried alongside each sample.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_vld  in  1  upstream sample valid.
- s_rdy  out  1  upstream ready.
- s_i  in  16  signed I component (two's complement).
- s_q  in  16  signed Q component (two's complement).
- s_tag  in  TAG_W  user tag.
- sq_vld  out  1  drives sqrt_u32 vld_in; single-cycle pulse per sample.
- sq_x  out  32  drives sqrt_u32 x; unsigned I²+Q².
- sq_rvld  in  1  from sqrt_u32 vld_out.
- sq_y  in  16  from sqrt_u32 y.
- m_vld  out  1  downstream result valid.
- m_rdy  in  1  downstream ready.
- m_mag  out  16  magnitude, i.e. sqrt_u32 result.
- m_tag  out  TAG_W  tag matching m_mag.
- outstanding  out  $clog2(CREDITS)+1  current credit count.
- err  out  1  sticky protocol error flag.

Behaviour:
Reset (rst=1, any time, asynchronous):
- All counters, FIFO pointers, pipeline valids, sq_vld, sq_x, m_vld and err clear to 0.
- s_rdy=1 once rst deasserts.
- Reset mid-operation discards every in-flight sample. The bench must reset sqrt_u32 together with this block.

Credits:
- Accept = s_vld & s_rdy.
- s_rdy = (outstanding < CREDITS). Derived from the register only; no combinational path from m_rdy or s_vld.
- Pop = m_vld & m_rdy.
- outstanding: +1 on accept, −1 on pop, unchanged when both occur in the same cycle.
- At outstanding == CREDITS with a pop in cycle N: s_rdy=0 in cycle N and 1 in cycle N+1.

Square pipeline:
- Stage 1, registered on accept: sign-extended products I·I and Q·Q, each held in 32 bits unsigned (max 2^30).
- Stage 2, registered: sum of the two products.
  - Max result is 2^31 at I=Q=−32768, so there is no overflow.
- sq_vld pulses exactly 2 cycles after the accept cycle, with sq_x valid in that same cycle.
- The pipeline never stalls; back-to-back accepts give back-to-back sq_vld pulses.
- sq_x holds its last value when sq_vld=0.

Tag FIFO (depth CREDITS, width TAG_W):
- Pushed on accept.
- Popped on pop.
- Cannot overflow, because credits bound it.

Result FIFO (depth CREDITS, width 16):
- Pushed with sq_y whenever sq_rvld=1.
- Popped on pop.
- m_vld = result FIFO not empty.
- m_mag is the result FIFO head; m_tag is the tag FIFO head. Both are stable while m_vld & ~m_rdy.
- Ordering is preserved, since sqrt_u32 is in-order.
- Push and pop in the same cycle are both honoured, including on an empty FIFO: the pushed word becomes visible the next cycle. There is no fall-through.

In-sqrt counter:
- +1 on sq_vld, −1 on sq_rvld.

err (sticky until rst):
- Set when sq_rvld=1 while the in-sqrt counter is 0 (spurious result). The spurious result is dropped and not pushed.
- Set when sq_rvld=1 while the result FIFO is full. The result is dropped.

Test Plan:
- Basic path: accept I=3, Q=4, tag=5 → sq_vld with sq_x=25 two cycles later. Drive sq_rvld with sq_y=5 → m_vld=1 next cycle with m_mag=5, m_tag=5. outstanding returns to 0 after the pop.
- Extremes: I=Q=−32768 → sq_x=0x8000_0000. I=32767, Q=0 → sq_x=0x3FFF_0001. I=Q=0 → sq_x=0.
- Credit exhaustion: m_rdy=0, continuous s_vld → exactly 16 accepts, then s_rdy=0 and outstanding=16. Raise m_rdy for one cycle → one pop and s_rdy=1 the following cycle. Also drive accept+pop in the same cycle at outstanding=15 → count stays 15.
- Ordering/backpressure: 8 samples with tags 0..7, results returned with random gaps, m_rdy toggled randomly → outputs in tag order 0..7 with correct magnitudes, no drops or duplicates.
- Error: sq_rvld pulse with nothing issued → err=1, m_vld stays 0, err remains 1 until rst.
- Reset mid-flight: assert rst with 4 outstanding and 2 results buffered → outputs cleared immediately (asynchronously), s_rdy=1 after deassert, first new sample tagged correctly.

Source files
------------

// File: rtl/mag_sqrt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mag_sqrt_ctrl
//  Description : Front/back-end controller around the sqrt_u32 stage.
//                Accepts signed I/Q samples with tags, computes I^2+Q^2 in a
//                two-stage pipeline, issues it to sqrt_u32 under a credit
//                limit, buffers returned roots and presents {mag, tag} in
//                order with backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module mag_sqrt_ctrl #(
  parameter int CREDITS = 16,
  parameter int TAG_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_vld,
  output logic                       s_rdy,
  input  logic [15:0]                s_i,
  input  logic [15:0]                s_q,
  input  logic [TAG_W-1:0]           s_tag,
  output logic                       sq_vld,
  output logic [31:0]                sq_x,
  input  logic                       sq_rvld,
  input  logic [15:0]                sq_y,
  output logic                       m_vld,
  input  logic                       m_rdy,
  output logic [15:0]                m_mag,
  output logic [TAG_W-1:0]           m_tag,
  output logic [$clog2(CREDITS):0]   outstanding,
  output logic                       err
);

  localparam int CW = $clog2(CREDITS) + 1;
  localparam int AW = $clog2(CREDITS);
  localparam logic [CW-1:0] C_CREDITS = CW'(CREDITS);
  localparam logic [CW-1:0] C_ONE     = CW'(1);

  // Handshake qualifiers
  logic w_accept;
  logic w_pop;

  // Square pipeline
  logic signed [31:0] w_i_ext;
  logic signed [31:0] w_q_ext;
  logic        [31:0] w_prod_i;
  logic        [31:0] w_prod_q;
  logic               r_v1;
  logic        [31:0] r_sq_i;
  logic        [31:0] r_sq_q;

  // Tag FIFO
  logic [TAG_W-1:0] r_tag_mem [CREDITS];
  logic [AW-1:0]    r_tag_wp;
  logic [AW-1:0]    r_tag_rp;

  // Result FIFO
  logic [15:0]      r_res_mem [CREDITS];
  logic [AW-1:0]    r_res_wp;
  logic [AW-1:0]    r_res_rp;
  logic [CW-1:0]    r_res_cnt;
  logic             w_res_full;
  logic             w_res_push;

  // Results expected back from sqrt_u32
  logic [CW-1:0]    r_insq;
  logic             w_insq_zero;
  logic             w_ret_ok;

  assign s_rdy    = (outstanding < C_CREDITS);
  assign w_accept = s_vld & s_rdy;
  assign w_pop    = m_vld & m_rdy;

  assign w_i_ext  = {{16{s_i[15]}}, s_i};
  assign w_q_ext  = {{16{s_q[15]}}, s_q};
  // Squares of 16-bit signed values never exceed 2^30, so the low 32 bits
  // of the signed product are the exact non-negative result.
  assign w_prod_i = w_i_ext * w_i_ext;
  assign w_prod_q = w_q_ext * w_q_ext;

  assign w_insq_zero = (r_insq == '0);
  assign w_res_full  = (r_res_cnt == C_CREDITS);
  // A result with no matching issue, or with no room, is dropped
  assign w_ret_ok    = sq_rvld & ~w_insq_zero;
  assign w_res_push  = w_ret_ok & ~w_res_full;

  assign m_vld = (r_res_cnt != '0);
  assign m_mag = r_res_mem[r_res_rp];
  assign m_tag = r_tag_mem[r_tag_rp];

  // Credit counter: samples accepted but not yet popped downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   outstanding <= outstanding + C_ONE;
        2'b01:   outstanding <= outstanding - C_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Stage 1: register the two squares on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_sq_i <= '0;
      r_sq_q <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_sq_i <= w_prod_i;
        r_sq_q <= w_prod_q;
      end
    end
  end

  // Stage 2: sum and issue to sqrt_u32; sq_x holds between issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_vld <= 1'b0;
      sq_x   <= '0;
    end else begin
      sq_vld <= r_v1;
      if (r_v1) begin
        sq_x <= r_sq_i + r_sq_q;
      end
    end
  end

  // Tag FIFO storage
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_mem[r_tag_wp] <= s_tag;
    end
  end

  // Tag FIFO pointers; occupancy is bounded by the credit count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_wp <= '0;
      r_tag_rp <= '0;
    end else begin
      if (w_accept) r_tag_wp <= r_tag_wp + 1'b1;
      if (w_pop)    r_tag_rp <= r_tag_rp + 1'b1;
    end
  end

  // Result FIFO storage
  always_ff @(posedge clk) begin
    if (w_res_push) begin
      r_res_mem[r_res_wp] <= sq_y;
    end
  end

  // Result FIFO pointers and occupancy; no fall-through on empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_wp  <= '0;
      r_res_rp  <= '0;
      r_res_cnt <= '0;
    end else begin
      if (w_res_push) r_res_wp <= r_res_wp + 1'b1;
      if (w_pop)      r_res_rp <= r_res_rp + 1'b1;
      case ({w_res_push, w_pop})
        2'b10:   r_res_cnt <= r_res_cnt + C_ONE;
        2'b01:   r_res_cnt <= r_res_cnt - C_ONE;
        default: r_res_cnt <= r_res_cnt;
      endcase
    end
  end

  // Count of samples issued to sqrt_u32 whose result has not returned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_insq <= '0;
    end else begin
      case ({sq_vld, w_ret_ok})
        2'b10:   r_insq <= r_insq + C_ONE;
        2'b01:   r_insq <= r_insq - C_ONE;
        default: r_insq <= r_insq;
      endcase
    end
  end

  // Sticky protocol error: spurious result or result with no buffer room
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (sq_rvld & (w_insq_zero | w_res_full)) begin
      err <= 1'b1;
    end
  end

endmodule
`default_nettype wire
